// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_CLOCKS_PER_BIT_115200 = 868;

    // Even parity of the data word; odd=1 inverts it to give odd parity.
    function automatic logic uart_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter that pulses tick for one cycle at every bit boundary.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = UART_CLOCKS_PER_BIT_115200
) (
    input  logic clock,
    input  logic resetn,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int CW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
    localparam logic [CW-1:0] LAST = CW'(clocks_per_bit - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (restart) begin
            count_d = LAST;
        end else if (enable) begin
            if (count_q == '0) begin
                tick    = 1'b1;
                count_d = LAST;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one word per frame from the upstream FIFO and serialises it
// as start bit, data LSB first, optional parity and one stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int width          = 8,
    parameter int clocks_per_bit = UART_CLOCKS_PER_BIT_115200,
    parameter int parity_enable  = 0,
    parameter int parity_odd     = 0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_data_out,
    output logic             fifo_read_enable,
    output logic             tx,
    output logic             busy
);

    localparam int BW = (width > 1) ? $clog2(width) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

    uart_tx_state_t   state_q, state_d;
    logic [width-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             baud_restart, baud_enable, baud_tick;

    // The timer is reloaded in FETCH so START gets a full bit period.
    assign baud_restart = (state_q == FETCH);
    assign baud_enable  = (state_q != IDLE) && (state_q != FETCH);

    uart_baud_tick #(
        .clocks_per_bit(clocks_per_bit)
    ) u_baud (
        .clock  (clock),
        .resetn (resetn),
        .restart(baud_restart),
        .enable (baud_enable),
        .tick   (baud_tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        parity_d = parity_q;
        tx_d     = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = FETCH;
            end
            FETCH: begin
                shift_d  = fifo_data_out;
                parity_d = uart_parity(64'(fifo_data_out), (parity_odd != 0));
                bit_d    = '0;
                state_d  = START;
            end
            START: begin
                tx_d = 1'b0;
                if (baud_tick) state_d = DATA;
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = (parity_enable != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                tx_d = parity_q;
                if (baud_tick) state_d = STOP;
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    assign tx               = tx_q;
    assign busy             = (state_q != IDLE);
    assign fifo_read_enable = resetn && (state_q == IDLE) && !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity, even, odd) each fed by a small FIFO model.
module tb_uart_tx;

    localparam int CPB = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic       fifo_empty [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0] data_out   [3];
    logic       rd_w [3];
    logic       tx_w [3];
    logic       busy_w [3];
    logic       pop_req [3] = '{1'b0, 1'b0, 1'b0};
    logic       push_req [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] push_val [3];
    logic [7:0] mem [3][16];
    int         wp [3] = '{0, 0, 0};
    int         rp [3] = '{0, 0, 0};

    logic [2:0] cap  [128];
    logic [2:0] expv [128];
    int checks = 0;
    int errors = 0;

    uart_tx #(.width(8), .clocks_per_bit(CPB), .parity_enable(0), .parity_odd(0)) dut_none (
        .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty[0]), .fifo_data_out(data_out[0]),
        .fifo_read_enable(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.width(8), .clocks_per_bit(CPB), .parity_enable(1), .parity_odd(0)) dut_even (
        .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty[1]), .fifo_data_out(data_out[1]),
        .fifo_read_enable(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.width(8), .clocks_per_bit(CPB), .parity_enable(1), .parity_odd(1)) dut_odd (
        .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty[2]), .fifo_data_out(data_out[2]),
        .fifo_read_enable(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    // Upstream FIFO model: write on push_req, registered read data the cycle after a pop.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) pop_req[i] = rd_w[i] && !fifo_empty[i];
    end

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (pop_req[i]) begin
                data_out[i] <= mem[i][rp[i][3:0]];
                rp[i] = rp[i] + 1;
            end
            if (push_req[i]) begin
                mem[i][wp[i][3:0]] = push_val[i];
                wp[i] = wp[i] + 1;
            end
            fifo_empty[i] <= (wp[i] == rp[i]);
        end
    end

    task automatic push(input int ch, input logic [7:0] v);
        push_val[ch] = v;
        push_req[ch] = 1'b1;
        @(posedge clock); #1;
        push_req[ch] = 1'b0;
    endtask

    // Records {tx, busy, read_enable} at each falling edge, then realigns to just after a rising edge.
    task automatic capture(input int ch, input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            cap[k] = {tx_w[ch], busy_w[ch], rd_w[ch]};
        end
        @(posedge clock); #1;
    endtask

    // Reference line: first start bit at sample s, each later frame nb*CPB+2 samples after the previous.
    task automatic model(input int ch, input int n, input logic [7:0] d0, input logic [7:0] d1,
                         input int s, input int len);
        int nb;
        int sf;
        logic [7:0] d;
        logic v;
        nb = (ch == 0) ? 10 : 11;
        for (int k = 0; k < len; k++) expv[k] = 3'b100;
        for (int f = 0; f < n; f++) begin
            d  = (f == 0) ? d0 : d1;
            sf = s + f * (nb * CPB + 2);
            if (sf - 3 >= 0) expv[sf-3][0] = 1'b1;
            for (int k = sf - 2; k <= sf - 2 + nb * CPB; k++)
                if (k >= 0 && k < len) expv[k][1] = 1'b1;
            for (int b = 0; b < nb; b++) begin
                if (b == 0)                  v = 1'b0;
                else if (b <= 8)             v = d[b-1];
                else if (b == 9 && ch != 0)  v = (^d) ^ (ch == 2);
                else                         v = 1'b1;
                for (int c = 0; c < CPB; c++) expv[sf + b * CPB + c][2] = v;
            end
        end
    endtask

    task automatic test_reset;
        int len;
        push(0, 8'h5A);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            for (int ch = 0; ch < 3; ch++) begin
                checks++;
                if (tx_w[ch] !== 1'b1 || busy_w[ch] !== 1'b0 || rd_w[ch] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold ch%0d tx=%b busy=%b rd=%b expected 1 0 0",
                             ch, tx_w[ch], busy_w[ch], rd_w[ch]);
                end
            end
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        len = 3 + 10 * CPB + 6;
        model(0, 1, 8'h5A, 8'h00, 3, len);
        capture(0, len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (cap[k] !== expv[k]) begin
                errors++;
                $display("FAIL after_reset sample %0d tx_busy_rd=%b expected %b", k, cap[k], expv[k]);
            end
        end
        checks++;
        if (rp[0] !== 1) begin
            errors++;
            $display("FAIL after_reset_pops got %0d expected 1", rp[0]);
        end
    endtask

    task automatic test_single;
        int len, base, nbusy, nrd;
        base = rp[0];
        push(0, 8'hA5);
        len = 3 + 10 * CPB + 6;
        model(0, 1, 8'hA5, 8'h00, 3, len);
        capture(0, len);
        nbusy = 0;
        nrd   = 0;
        for (int k = 0; k < len; k++) begin
            nbusy += int'(cap[k][1]);
            nrd   += int'(cap[k][0]);
            checks++;
            if (cap[k] !== expv[k]) begin
                errors++;
                $display("FAIL a5_line sample %0d tx_busy_rd=%b expected %b", k, cap[k], expv[k]);
            end
        end
        checks++;
        if (nbusy !== 1 + 10 * CPB) begin
            errors++;
            $display("FAIL a5_busy_cycles got %0d expected %0d", nbusy, 1 + 10 * CPB);
        end
        checks++;
        if (nrd !== 1 || rp[0] - base !== 1) begin
            errors++;
            $display("FAIL a5_pops rd_pulses=%0d pops=%0d expected 1 1", nrd, rp[0] - base);
        end
    endtask

    task automatic test_back_to_back;
        int len, base, nrd;
        base = rp[0];
        push(0, 8'h00);
        push(0, 8'hFF);
        len = 2 + 2 * (10 * CPB + 2) + 4;
        model(0, 2, 8'h00, 8'hFF, 2, len);
        capture(0, len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (cap[k] !== expv[k]) begin
                errors++;
                $display("FAIL b2b_line sample %0d tx_busy_rd=%b expected %b", k, cap[k], expv[k]);
            end
        end
        nrd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            nrd += int'(rd_w[0]);
        end
        @(posedge clock); #1;
        checks++;
        if (fifo_empty[0] !== 1'b1 || rp[0] - base !== 2 || nrd !== 0) begin
            errors++;
            $display("FAIL b2b_drain empty=%b pops=%0d late_rd=%0d expected 1 2 0",
                     fifo_empty[0], rp[0] - base, nrd);
        end
    endtask

    task automatic test_parity;
        int len, s;
        logic par;
        s   = 3;
        len = s + 11 * CPB + 6;
        for (int ch = 1; ch <= 2; ch++) begin
            push(ch, 8'h07);
            model(ch, 1, 8'h07, 8'h00, s, len);
            capture(ch, len);
            for (int k = 0; k < len; k++) begin
                checks++;
                if (cap[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL parity_line ch%0d sample %0d tx_busy_rd=%b expected %b",
                             ch, k, cap[k], expv[k]);
                end
            end
            par = (ch == 1) ? 1'b1 : 1'b0;
            checks++;
            if (cap[s + 9 * CPB + 1][2] !== par) begin
                errors++;
                $display("FAIL parity_bit ch%0d got %b expected %b", ch, cap[s + 9 * CPB + 1][2], par);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int base, len;
        push(0, 8'hC3);
        repeat (20) @(posedge clock);
        #1;
        checks++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_pre tx=%b busy=%b expected 0 1", tx_w[0], busy_w[0]);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rd_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_reset tx=%b busy=%b rd=%b expected 1 0 0", tx_w[0], busy_w[0], rd_w[0]);
        end
        base = rp[0];
        push(0, 8'h3C);
        @(posedge clock); #1;
        checks++;
        if (rp[0] !== base) begin
            errors++;
            $display("FAIL mid_frame_no_pop pops=%0d expected 0", rp[0] - base);
        end
        resetn = 1'b1;
        len = 3 + 10 * CPB + 6;
        model(0, 1, 8'h3C, 8'h00, 3, len);
        capture(0, len);
        for (int k = 0; k < len; k++) begin
            checks++;
            if (cap[k] !== expv[k]) begin
                errors++;
                $display("FAIL post_reset_3c sample %0d tx_busy_rd=%b expected %b", k, cap[k], expv[k]);
            end
        end
        checks++;
        if (rp[0] - base !== 1) begin
            errors++;
            $display("FAIL post_reset_pops got %0d expected 1", rp[0] - base);
        end
    endtask

    task automatic test_empty_during_frame;
        int len, base, overlap;
        base = rp[2];
        push(2, 8'h96);
        len = 3 + 2 * (11 * CPB + 2) + 4;
        model(2, 2, 8'h96, 8'h2D, 3, len);
        fork
            capture(2, len);
            begin
                repeat (20) @(posedge clock);
                #1;
                push(2, 8'h2D);
            end
        join
        overlap = 0;
        for (int k = 0; k < len; k++) begin
            overlap += int'(cap[k][1] & cap[k][0]);
            checks++;
            if (cap[k] !== expv[k]) begin
                errors++;
                $display("FAIL late_push_line sample %0d tx_busy_rd=%b expected %b", k, cap[k], expv[k]);
            end
        end
        checks++;
        if (overlap !== 0 || rp[2] - base !== 2) begin
            errors++;
            $display("FAIL late_push_pops rd_while_busy=%0d pops=%0d expected 0 2", overlap, rp[2] - base);
        end
    endtask

    task automatic test_random;
        int ch, n, s, len, base, nb;
        logic [7:0] d0, d1;
        for (int it = 0; it < 6; it++) begin
            ch   = int'($urandom_range(0, 2));
            n    = int'($urandom_range(1, 2));
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            base = rp[ch];
            nb   = (ch == 0) ? 10 : 11;
            push(ch, d0);
            if (n == 2) push(ch, d1);
            s   = (n == 1) ? 3 : 2;
            len = s + n * (nb * CPB + 2) + 4;
            model(ch, n, d0, d1, s, len);
            capture(ch, len);
            for (int k = 0; k < len; k++) begin
                checks++;
                if (cap[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL random_line it%0d ch%0d d=%h/%h sample %0d tx_busy_rd=%b expected %b",
                             it, ch, d0, d1, k, cap[k], expv[k]);
                end
            end
            checks++;
            if (rp[ch] - base !== n) begin
                errors++;
                $display("FAIL random_pops it%0d got %0d expected %0d", it, rp[ch] - base, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_empty_during_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
